// File: rtl/pipe_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
package pipe_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      HOLD,
      DROP
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return addr & WORD_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/fetch_skid.sv
// IF_ID output register plus a one-entry hold buffer that parks a fetched
// word while decode is stalled.
module fetch_skid
   import pipe_pkg::*;
#(
   parameter logic [31:0] NOP = NOP_INSTR
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        flush_i,
   input  logic        load_i,
   input  logic        capture_i,
   input  logic        drain_i,
   input  logic        id_ready_i,
   input  logic [31:0] mem_instr_i,
   input  logic [31:0] mem_pc_i,
   output logic        id_valid_o,
   output logic [31:0] id_instr_o,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_pc4_o
);

   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc4_q, pc4_d;
   logic [31:0] hold_instr_q, hold_instr_d;
   logic [31:0] hold_pc_q, hold_pc_d;

   // NOTE: every always_comb output gets its default first, so no path can infer a latch.
   always_comb begin
      valid_d      = valid_q;
      instr_d      = instr_q;
      pc_d         = pc_q;
      pc4_d        = pc4_q;
      hold_instr_d = hold_instr_q;
      hold_pc_d    = hold_pc_q;

      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         instr_d = mem_instr_i;
         pc_d    = mem_pc_i;
         pc4_d   = mem_pc_i + PC_STEP;
      end else if (drain_i) begin
         valid_d = 1'b1;
         instr_d = hold_instr_q;
         pc_d    = hold_pc_q;
         pc4_d   = hold_pc_q + PC_STEP;
      end else if (id_ready_i) begin
         valid_d = 1'b0;
      end

      if (capture_i) begin
         hold_instr_d = mem_instr_i;
         hold_pc_d    = mem_pc_i;
      end
   end

   // NOTE: the hold buffer is only two words, so it is reset with everything else;
   // emptiness is tracked by the parent FSM being in HOLD.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         valid_q      <= 1'b0;
         instr_q      <= NOP;
         pc_q         <= '0;
         pc4_q        <= '0;
         hold_instr_q <= NOP;
         hold_pc_q    <= '0;
      end else begin
         valid_q      <= valid_d;
         instr_q      <= instr_d;
         pc_q         <= pc_d;
         pc4_q        <= pc4_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
      end
   end

   assign id_valid_o = valid_q;
   assign id_instr_o = valid_q ? instr_q : NOP;
   assign id_pc_o    = pc_q;
   assign id_pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, runs a single-outstanding req/ack to
// instruction memory and feeds decode through fetch_skid.
module fetch_stage
   import pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter logic [31:0] NOP      = NOP_INSTR
) (
   input  logic        CLK,
   input  logic        RSTn,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc4
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  addr_q, addr_d;

   logic        ack_acc;
   logic        slot_free;
   logic [31:0] rpc;
   logic        load, capture, drain, flush;

   assign imem_req  = (state_q == WAIT) || (state_q == DROP);
   assign imem_addr = addr_q;
   assign ack_acc   = imem_ack && imem_req;
   assign slot_free = !id_valid || id_ready;
   assign rpc       = align_pc(redirect_pc);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      load    = 1'b0;
      capture = 1'b0;
      drain   = 1'b0;
      flush   = redirect_valid;

      unique case (state_q)
         IDLE: begin
            state_d = WAIT;
            pc_d    = redirect_valid ? rpc : pc_q;
            addr_d  = redirect_valid ? rpc : pc_q;
         end
         WAIT: begin
            if (redirect_valid && ack_acc) begin
               pc_d   = rpc;
               addr_d = rpc;
            end else if (redirect_valid) begin
               pc_d    = rpc;
               state_d = DROP;
            end else if (ack_acc && slot_free) begin
               load   = 1'b1;
               pc_d   = pc_q + PC_STEP;
               addr_d = pc_q + PC_STEP;
            end else if (ack_acc) begin
               capture = 1'b1;
               pc_d    = pc_q + PC_STEP;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               pc_d    = rpc;
               addr_d  = rpc;
               state_d = WAIT;
            end else if (id_ready) begin
               drain   = 1'b1;
               addr_d  = pc_q;
               state_d = WAIT;
            end
         end
         DROP: begin
            // The stale request stays on the bus until memory acks it; the
            // newest redirect target is what gets fetched next.
            if (redirect_valid) pc_d = rpc;
            if (ack_acc) begin
               addr_d  = redirect_valid ? rpc : pc_q;
               state_d = WAIT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
      end
   end

   fetch_skid #(
      .NOP(NOP)
   ) u_skid (
      .CLK        (CLK),
      .RSTn       (RSTn),
      .flush_i    (flush),
      .load_i     (load),
      .capture_i  (capture),
      .drain_i    (drain),
      .id_ready_i (id_ready),
      .mem_instr_i(imem_rdata),
      .mem_pc_i   (addr_q),
      .id_valid_o (id_valid),
      .id_instr_o (id_instr),
      .id_pc_o    (id_pc),
      .id_pc4_o   (id_pc4)
   );

endmodule
